// File: rtl/div_iter.sv
// div_iter: iterative signed fixed-point divider, quot = trunc0((a << BIN_POS) / b), one quotient bit per clock.
// Build option DIV_SAT_EN: saturate quot on overflow / divide-by-zero instead of wrapping.
module div_iter #(
   parameter int DATA_WIDTH = 16,
   parameter int BIN_POS    = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] quot,
   output logic                  dbz,
   output logic                  ovf
);
   localparam int W  = DATA_WIDTH;
   localparam int N  = W + BIN_POS;
   localparam int CW = $clog2(N + 1);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
   localparam logic [N-1:0] LIM  = N'(1) << (W - 1);
   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [W:0]    rem, rem_sh;
   logic [N-1:0]  dvd, q;
   logic [W-1:0]  bm, a_mag, b_mag, q_lo, wrap, res, dbz_res;
   logic          neg, bz, ge, ovf_c;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   always_comb begin
      a_mag  = a[W-1] ? -a : a;
      b_mag  = b[W-1] ? -b : b;
      rem_sh = {rem[W-1:0], dvd[N-1]};
      // rem[W] is the carry of the shifted partial remainder; it is never set but keeps the compare exact
      ge     = rem[W] | (rem_sh >= {1'b0, bm});
      q_lo   = q[W-1:0];
      ovf_c  = neg ? q > LIM : q >= LIM;
      wrap   = neg ? -q_lo : q_lo;
`ifdef DIV_SAT_EN
      res     = ovf_c ? (neg ? MINV : MAXV) : wrap;
      dbz_res = neg ? MINV : MAXV;
`else
      res     = wrap;
      dbz_res = '0;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         dvd   <= '0;
         q     <= '0;
         bm    <= '0;
         neg   <= 1'b0;
         bz    <= 1'b0;
         quot  <= '0;
         dbz   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               neg   <= a[W-1] ^ b[W-1];
               bm    <= b_mag;
               bz    <= b == '0;
               dvd   <= N'(a_mag) << BIN_POS;
               rem   <= '0;
               q     <= '0;
               // a zero divisor skips the iterations but still spends the finishing cycle
               cnt   <= b == '0 ? '0 : CW'(N);
               state <= CALC;
            end
            CALC: if (cnt == '0) begin
               quot  <= bz ? dbz_res : res;
               dbz   <= bz;
               ovf   <= !bz && ovf_c;
               state <= DONE;
            end else begin
               rem <= ge ? rem_sh - {1'b0, bm} : rem_sh;
               dvd <= dvd << 1;
               q   <= {q[N-2:0], ge};
               cnt <= cnt - 1'b1;
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and random checks of div_iter (Q8.8) against an integer-arithmetic reference.
module tb_div_iter;
   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, dbz, ovf;
   logic [15:0] a, b, quot;
   int total = 0, bad = 0;

   div_iter #(.DATA_WIDTH(16), .BIN_POS(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .quot(quot), .dbz(dbz), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [15:0] ta, input logic [15:0] tb,
                                 output logic [15:0] q, output logic d, output logic o);
      longint n, t;
      n = longint'($signed(ta)) * 256;
      if (tb == 16'h0) begin
         d = 1'b1;
         o = 1'b0;
`ifdef DIV_SAT_EN
         q = $signed(ta) < 0 ? 16'h8000 : 16'h7FFF;
`else
         q = 16'h0000;
`endif
      end else begin
         t = n / longint'($signed(tb));
         d = 1'b0;
         o = t > 32767 || t < -32768;
`ifdef DIV_SAT_EN
         q = o ? (t < 0 ? 16'h8000 : 16'h7FFF) : t[15:0];
`else
         q = t[15:0];
`endif
      end
   endfunction

   task automatic start(input logic [15:0] ta, input logic [15:0] tb);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_before_start", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b1; a = ta; b = tb;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_after_accept", {31'b0, out_valid}, 32'd0);
      chk("in_ready_after_accept", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input int hold);
      int lat;
      logic [15:0] eq;
      logic ed, eo;
      model(ta, tb, eq, ed, eo);
      start(ta, tb);
      wait_done(lat);
      chk($sformatf("latency a=%h b=%h", ta, tb), lat, tb == 16'h0 ? 32'd1 : 32'd25);
      chk($sformatf("quot a=%h b=%h", ta, tb), {16'b0, quot}, {16'b0, eq});
      chk($sformatf("dbz a=%h b=%h", ta, tb), {31'b0, dbz}, {31'b0, ed});
      chk($sformatf("ovf a=%h b=%h", ta, tb), {31'b0, ovf}, {31'b0, eo});
      repeat (hold) @(posedge clk);
      #1 chk("out_valid_held", {31'b0, out_valid}, 32'd1);
      release_result();
   endtask

   initial begin
      int lat;
      logic [15:0] q0, ra, rb;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #12;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_quot", {16'b0, quot}, 32'd0);
      chk("rst_flags", {30'b0, dbz, ovf}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      do_op(16'h0300, 16'h0200, 0);
      do_op(16'hFD00, 16'h0200, 1);
      do_op(16'hFFFF, 16'h0200, 0);
      do_op(16'h0100, 16'h0000, 0);
      do_op(16'h8000, 16'h0000, 2);
      do_op(16'h7F00, 16'h0001, 0);
      do_op(16'h8000, 16'hFFFF, 0);
      do_op(16'h8000, 16'h8000, 0);
      do_op(16'h0100, 16'h8000, 0);

      // busy-period requests must be ignored and the result held while stalled
      start(16'h0300, 16'h0200);
      in_valid = 1'b1; a = 16'h1234; b = 16'h0001;
      wait_done(lat);
      chk("stall_latency", lat, 32'd25);
      chk("stall_quot", {16'b0, quot}, 32'h0180);
      q0 = quot;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_stable", {16'b0, quot}, {16'b0, q0});
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      release_result();
      do_op(16'h0500, 16'h0100, 0);

      // asynchronous reset in the middle of an iteration
      start(16'h0100, 16'h0200);
      repeat (14) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("midrst_quot", {16'b0, quot}, 32'd0);
      chk("midrst_flags", {30'b0, dbz, ovf}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_op(16'h0100, 16'h0100, 0);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0: ra = 16'h8000;
            1: ra = 16'h7FFF;
            2: ra = 16'h0000;
            default: ra = 16'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0: rb = 16'h0000;
            1: rb = 16'h8000;
            2: rb = 16'hFFFF;
            3: rb = 16'($urandom_range(1, 4));
            default: rb = 16'($urandom);
         endcase
         do_op(ra, rb, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
